pwm_deadtime_gen: RTL and testbench

Multi-channel, clocked PWM generator with per-channel duty and phase, double-buffered updates and complementary high/low gate outputs with programmable dead time. It is the synthesizable successor of the single-channel behavioural `PWM` source. It drives switch-control inputs of emulated power stages, such as half bridges feeding the `filter` models, on the FPGA emulation clock.

---
 rtl/pwm_deadtime_gen.sv | 192 +++++++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// Multi-channel PWM generator: shared period counter, double-buffered per-channel
// duty/phase, complementary gate outputs with programmable dead time.
module pwm_deadtime_gen #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int DT_W  = 8,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [CH_W-1:0]  upd_ch,
    input  logic [CNT_W-1:0] upd_duty,
    input  logic [CNT_W-1:0] upd_phase,
    output logic [N_CH-1:0]  ctrl_hi,
    output logic [N_CH-1:0]  ctrl_lo,
    output logic             wrap
);

    // state | meaning
    // OFF   | disabled, both gates low
    // DEAD  | both gates low while raw settles for dt_a+1 cycles toward target
    // HI    | high-side gate on
    // LO    | low-side gate on
    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HI, ST_LO} st_t;

    logic [CNT_W-1:0] cnt, per_a;
    logic [DT_W-1:0]  dt_a;
    logic [CNT_W-1:0] duty_s [N_CH];
    logic [CNT_W-1:0] phase_s[N_CH];
    logic [CNT_W-1:0] duty_a [N_CH];
    logic [CNT_W-1:0] phase_a[N_CH];
    logic [CNT_W-1:0] duty_ld [N_CH];
    logic [CNT_W-1:0] phase_ld[N_CH];
    logic [CNT_W:0]   loc[N_CH];
    logic [CNT_W:0]   per_p1, per_a_p1;
    logic             en_d, running, at_end, load, upd_fire;
    logic [N_CH-1:0]  raw;

    st_t             state[N_CH], state_nx[N_CH];
    logic [N_CH-1:0] tgt, tgt_nx;
    logic [DT_W-1:0] dcnt[N_CH], dcnt_nx[N_CH];

    function automatic logic [CNT_W-1:0] mod_phase(input logic [CNT_W-1:0] p,
                                                   input logic [CNT_W:0]   m);
        logic [CNT_W:0] r;
        r = {1'b0, p} % m;
        return r[CNT_W-1:0];
    endfunction

    assign running  = en & en_d;
    assign at_end   = (cnt >= per_a);
    assign wrap     = ~rst & running & at_end;
    // First enabled cycle forces a load so a run never starts on stale actives.
    assign load     = en & (~en_d | at_end);
    assign upd_fire = upd_valid & upd_ready;
    assign per_p1   = {1'b0, period} + (CNT_W+1)'(1);
    assign per_a_p1 = {1'b0, per_a} + (CNT_W+1)'(1);

    // A same-cycle shadow write goes straight through to the active load.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            duty_ld[i]  = duty_s[i];
            phase_ld[i] = phase_s[i];
            if (upd_fire && upd_ch == CH_W'(i)) begin
                duty_ld[i]  = upd_duty;
                phase_ld[i] = upd_phase;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            loc[i] = {1'b0, cnt} + {1'b0, phase_a[i]};
            if (loc[i] >= per_a_p1)
                loc[i] = loc[i] - per_a_p1;
            raw[i] = (loc[i] < {1'b0, duty_a[i]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            per_a     <= '0;
            dt_a      <= '0;
            en_d      <= 1'b0;
            upd_ready <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_s[i]  <= '0;
                phase_s[i] <= '0;
                duty_a[i]  <= '0;
                phase_a[i] <= '0;
            end
        end else begin
            en_d      <= en;
            upd_ready <= 1'b1;
            if (!running || at_end)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            for (int i = 0; i < N_CH; i++) begin
                if (upd_fire && upd_ch == CH_W'(i)) begin
                    duty_s[i]  <= upd_duty;
                    phase_s[i] <= upd_phase;
                end
            end
            if (load) begin
                per_a <= period;
                dt_a  <= dead_time;
                for (int i = 0; i < N_CH; i++) begin
                    duty_a[i]  <= duty_ld[i];
                    phase_a[i] <= mod_phase(phase_ld[i], per_p1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= ST_OFF;
                dcnt[i]  <= '0;
            end
        end else begin
            tgt <= tgt_nx;
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nx[i];
                dcnt[i]  <= dcnt_nx[i];
            end
        end
    end

    always_comb begin
        tgt_nx = tgt;
        for (int i = 0; i < N_CH; i++) begin
            state_nx[i] = state[i];
            dcnt_nx[i]  = dcnt[i];
            case (state[i])
                ST_OFF: begin
                    if (running) begin
                        state_nx[i] = ST_DEAD;
                        tgt_nx[i]   = raw[i];
                        dcnt_nx[i]  = '0;
                    end
                end
                ST_DEAD: begin
                    if (raw[i] != tgt[i]) begin
                        tgt_nx[i]  = raw[i];
                        dcnt_nx[i] = '0;
                    end else if (dcnt[i] >= dt_a) begin
                        state_nx[i] = tgt[i] ? ST_HI : ST_LO;
                        dcnt_nx[i]  = '0;
                    end else begin
                        dcnt_nx[i] = dcnt[i] + DT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!raw[i]) begin
                        state_nx[i] = ST_DEAD;
                        tgt_nx[i]   = 1'b0;
                        dcnt_nx[i]  = '0;
                    end
                end
                ST_LO: begin
                    if (raw[i]) begin
                        state_nx[i] = ST_DEAD;
                        tgt_nx[i]   = 1'b1;
                        dcnt_nx[i]  = '0;
                    end
                end
                default: state_nx[i] = ST_OFF;
            endcase
            if (!en) begin
                state_nx[i] = ST_OFF;
                dcnt_nx[i]  = '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ctrl_hi[i] = (state[i] == ST_HI);
            ctrl_lo[i] = (state[i] == ST_LO);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Randomised scoreboard bench for pwm_deadtime_gen: a history-based reference model
// predicts gate outputs, wrap and upd_ready every cycle; a monitor compares them.
module tb_pwm_deadtime_gen;
    localparam int N_CH  = 2;
    localparam int CNT_W = 16;
    localparam int DT_W  = 8;
    localparam int CH_W  = 1;
    localparam int HIST  = 64;

    logic             clk, rst, en, upd_valid, upd_ready, wrap;
    logic [CNT_W-1:0] period, upd_duty, upd_phase;
    logic [DT_W-1:0]  dead_time;
    logic [CH_W-1:0]  upd_ch;
    logic [N_CH-1:0]  ctrl_hi, ctrl_lo;

    pwm_deadtime_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .dead_time(dead_time),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_ch(upd_ch),
        .upd_duty(upd_duty), .upd_phase(upd_phase),
        .ctrl_hi(ctrl_hi), .ctrl_lo(ctrl_lo), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mon_cyc = 0;

    typedef struct { bit run; bit [N_CH-1:0] raw; } hist_t;
    typedef struct { bit [N_CH-1:0] hi; bit [N_CH-1:0] lo; bit wrap; bit ready; } exp_t;
    hist_t hist[$];
    exp_t  exp_q[$];

    // Reference model state: plain integers describing the spec-level registers.
    int m_cnt = 0, m_per = 0, m_dt = 0;
    int m_duty_s[N_CH], m_phase_s[N_CH], m_duty_a[N_CH], m_phase_a[N_CH];
    bit m_en_d = 0, m_ready = 0;
    int m_loc, m_d, m_p, m_nxt;
    bit m_run, m_fire, m_ld;
    hist_t m_h;
    exp_t  m_e;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            m_duty_s[i] = 0; m_phase_s[i] = 0; m_duty_a[i] = 0; m_phase_a[i] = 0;
        end
    end

    // A gate is on iff raw held its level for the last dt+2 running cycles.
    always @(negedge clk) begin
        m_run = !rst && en && m_en_d;
        for (int i = 0; i < N_CH; i++) begin
            m_loc = (m_cnt + m_phase_a[i]) % (m_per + 1);
            m_h.raw[i] = (m_loc < m_duty_a[i]);
        end
        for (int i = 0; i < N_CH; i++) begin
            m_e.hi[i] = (hist.size() >= m_dt + 2);
            m_e.lo[i] = m_e.hi[i];
            if (hist.size() >= m_dt + 2) begin
                for (int k = 0; k < m_dt + 2; k++) begin
                    if (!hist[k].run || !hist[k].raw[i]) m_e.hi[i] = 1'b0;
                    if (!hist[k].run ||  hist[k].raw[i]) m_e.lo[i] = 1'b0;
                end
            end
        end
        m_e.wrap  = m_run && (m_cnt >= m_per);
        m_e.ready = m_ready;
        exp_q.push_back(m_e);
        m_h.run = m_run;
        hist.push_front(m_h);
        if (hist.size() > HIST) void'(hist.pop_back());

        if (rst) begin
            m_cnt = 0; m_per = 0; m_dt = 0; m_en_d = 0; m_ready = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_duty_s[i] = 0; m_phase_s[i] = 0; m_duty_a[i] = 0; m_phase_a[i] = 0;
            end
        end else begin
            m_fire = upd_valid && m_ready;
            m_ld   = en && (!m_en_d || m_cnt >= m_per);
            m_nxt  = (m_run && m_cnt < m_per) ? m_cnt + 1 : 0;
            if (m_ld) begin
                for (int i = 0; i < N_CH; i++) begin
                    m_d = (m_fire && upd_ch == i) ? int'(upd_duty)  : m_duty_s[i];
                    m_p = (m_fire && upd_ch == i) ? int'(upd_phase) : m_phase_s[i];
                    m_duty_a[i]  = m_d;
                    m_phase_a[i] = m_p % (int'(period) + 1);
                end
                m_per = int'(period);
                m_dt  = int'(dead_time);
            end
            if (m_fire && upd_ch < N_CH) begin
                m_duty_s[upd_ch]  = int'(upd_duty);
                m_phase_s[upd_ch] = int'(upd_phase);
            end
            m_cnt = m_nxt; m_en_d = en; m_ready = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cycle %0d: got %0h, expected %0h", name, mon_cyc, act, req);
        end
    endtask

    exp_t e_mon;
    always begin
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("ctrl_hi",    32'(ctrl_hi),   32'(e_mon.hi));
            chk("ctrl_lo",    32'(ctrl_lo),   32'(e_mon.lo));
            chk("wrap",       32'(wrap),      32'(e_mon.wrap));
            chk("upd_ready",  32'(upd_ready), 32'(e_mon.ready));
            chk("no_overlap", 32'(ctrl_hi & ctrl_lo), 32'd0);
            mon_cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd(input int ch, input int duty, input int phase);
        upd_valid = 1'b1;
        upd_ch    = CH_W'(ch);
        upd_duty  = CNT_W'(duty);
        upd_phase = CNT_W'(phase);
        tick(1);
        upd_valid = 1'b0;
    endtask

    task automatic wait_wrap(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick(1);
            if (wrap === 1'b1) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: got no wrap, expected one within 60 cycles", name);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = '0; dead_time = '0;
        upd_valid = 1'b0; upd_ch = '0; upd_duty = '0; upd_phase = '0;
        tick(3);
        rst = 1'b0;
        tick(4);

        // 50 % duty, no dead time
        period = 16'd9; dead_time = 8'd0;
        upd(0, 5, 0);
        upd(1, 0, 0);
        en = 1'b1;
        tick(40);

        // dead time 2, ch1 shifted complement
        en = 1'b0; tick(2);
        dead_time = 8'd2;
        upd(1, 5, 5);
        en = 1'b1;
        tick(40);

        // double buffering: mid-period write, then write coincident with wrap
        wait_wrap("wrap_mid");
        tick(3);
        upd(0, 8, 0);
        tick(25);
        wait_wrap("wrap_coinc");
        upd(0, 3, 0);
        tick(25);

        // extremes: always low / always high
        upd(0, 0, 0);
        upd(1, 12, 0);
        tick(30);

        // period shrink 9 -> 3 late in the period
        upd(0, 5, 0);
        upd(1, 2, 1);
        wait_wrap("wrap_shrink");
        tick(7);
        period = 16'd3;
        tick(25);

        // disruptions: en drop mid-run, then reset mid-run
        period = 16'd9;
        tick(13);
        en = 1'b0; tick(1);
        en = 1'b1; tick(25);
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(20);

        // randomised traffic
        for (int c = 0; c < 2000; c++) begin
            upd_valid = ($urandom_range(3) == 0);
            upd_ch    = CH_W'($urandom_range(N_CH - 1));
            upd_duty  = CNT_W'($urandom_range(int'(period) + 3));
            upd_phase = CNT_W'($urandom_range(2 * int'(period) + 1));
            if ($urandom_range(49) == 0) period = CNT_W'($urandom_range(15));
            if ($urandom_range(99) == 0) begin
                en = ~en;
                if (!en) dead_time = DT_W'($urandom_range(4));
            end
            rst = ($urandom_range(299) == 0);
            tick(1);
        end
        upd_valid = 1'b0; rst = 1'b0;
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
